// File: rtl/lsu_pkg.sv
// lsu_pkg: shared states, funct3 codes and byte-enable helper for the load/store unit
package lsu_pkg;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  function automatic logic [3:0] be_gen(input logic [2:0] f3, input logic [1:0] a);
    return f3[1:0] == F3_LB[1:0] ? 4'b0001 << a :
           f3[1:0] == F3_LH[1:0] ? 4'b0011 << a : 4'b1111;
  endfunction
endpackage

// File: rtl/load_extend.sv
// load_extend: shifts the raw word into place and sign/zero-extends it by funct3
module load_extend import lsu_pkg::*; #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] raw,
  input  logic [1:0]      off,
  input  logic [2:0]      f3,
  output logic [XLEN-1:0] res
);
  logic [XLEN-1:0] sh;
  always_comb begin
    sh  = raw >> {off, 3'b000};
    res = f3 == F3_LB  ? {{(XLEN-8){sh[7]}}, sh[7:0]} :
          f3 == F3_LBU ? {{(XLEN-8){1'b0}}, sh[7:0]} :
          f3 == F3_LH  ? {{(XLEN-16){sh[15]}}, sh[15:0]} :
          f3 == F3_LHU ? {{(XLEN-16){1'b0}}, sh[15:0]} : sh;
  end
endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: MEM-stage load/store sequencer over a valid/ready data-memory port
module lsu_ctrl import lsu_pkg::*; #(
  parameter int XLEN        = 32,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            MemReadM,
  input  logic            MemWriteM,
  input  logic [2:0]      funct3M,
  input  logic [XLEN-1:0] ALUResultM,
  input  logic [XLEN-1:0] WriteDataM,
  input  logic            HoldM,
  output logic            dmem_req_valid,
  input  logic            dmem_req_ready,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  output logic [3:0]      dmem_be,
  input  logic            dmem_rsp_valid,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            StallLsuM,
  output logic [XLEN-1:0] ReadDataM,
  output logic            DoneM,
  output logic            MisalignM,
  output logic            BusErrM
);
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  state_e state_q, state_d;
  logic [XLEN-1:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d, ext;
  logic [1:0] off_q, off_d;
  logic [3:0] be_q, be_d;
  logic [2:0] f3_q, f3_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic we_q, we_d, mis_q, mis_d, err_q, err_d, acc, mis;
  load_extend #(.XLEN(XLEN)) u_ext (.raw(rdata_q), .off(off_q), .f3(f3_q), .res(ext));
  always_comb begin
    acc = MemReadM | MemWriteM;
    mis = (funct3M[1:0] == 2'b01 && ALUResultM[0]) || (funct3M[1] && |ALUResultM[1:0]);
    state_d = state_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    off_d = off_q;
    be_d = be_q;
    f3_d = f3_q;
    we_d = we_q;
    mis_d = mis_q;
    err_d = err_q;
    cnt_d = cnt_q;
    dmem_req_valid = 1'b0;
    StallLsuM = 1'b0;
    DoneM = 1'b0;
    MisalignM = 1'b0;
    BusErrM = 1'b0;
    ReadDataM = '0;
    case (state_q)
      IDLE: if (acc) begin
        StallLsuM = 1'b1;
        addr_d = {ALUResultM[XLEN-1:2], 2'b00};
        off_d = ALUResultM[1:0];
        be_d = be_gen(funct3M, ALUResultM[1:0]);
        f3_d = funct3M;
        we_d = MemWriteM & ~MemReadM;
        wdata_d = funct3M[1:0] == 2'b00 ? {(XLEN/8){WriteDataM[7:0]}} :
                  funct3M[1:0] == 2'b01 ? {(XLEN/16){WriteDataM[15:0]}} : WriteDataM;
        mis_d = mis;
        err_d = 1'b0;
        rdata_d = '0;
        cnt_d = '0;
        state_d = mis ? DONE : REQ;
      end
      REQ: begin
        dmem_req_valid = 1'b1;
        StallLsuM = 1'b1;
        rdata_d = dmem_req_ready && dmem_rsp_valid ? dmem_rdata : rdata_q;
        state_d = !dmem_req_ready ? REQ : dmem_rsp_valid ? DONE : WAIT;
      end
      WAIT: begin
        StallLsuM = 1'b1;
        cnt_d = cnt_q + 1'b1;
        BusErrM = !dmem_rsp_valid && cnt_q == CW'(TIMEOUT_CYC - 1);
        err_d = BusErrM;
        rdata_d = dmem_rsp_valid ? dmem_rdata : rdata_q;
        state_d = dmem_rsp_valid || BusErrM ? DONE : WAIT;
      end
      default: begin
        DoneM = 1'b1;
        MisalignM = mis_q;
        ReadDataM = we_q || mis_q || err_q ? '0 : ext;
        state_d = HoldM ? DONE : IDLE;
      end
    endcase
    dmem_we    = dmem_req_valid & we_q;
    dmem_addr  = dmem_req_valid ? addr_q : '0;
    dmem_wdata = dmem_req_valid ? wdata_q : '0;
    dmem_be    = dmem_req_valid ? be_q : '0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      off_q <= '0;
      be_q <= '0;
      f3_q <= '0;
      we_q <= 1'b0;
      mis_q <= 1'b0;
      err_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      off_q <= off_d;
      be_q <= be_d;
      f3_q <= f3_d;
      we_q <= we_d;
      mis_q <= mis_d;
      err_q <= err_d;
      cnt_q <= cnt_d;
    end
  end
endmodule
